pd_filter_ntap: RTL and testbench
=================================

Name: pd_filter_ntap

Overview:
- Parametrised successor of the two-tap PD controller block: signed discrete-time controller u_k = sum over i of b_i * e_(k-i), with NTAP taps (tap 0 = current error).
- Uses one time-shared multiplier and accumulator, one tap per cycle, started by a one-cycle stp pulse.
- Adds an output window with saturation and a saturation flag.
- Sits between the error subtractor and the actuator/PWM stage of the control loop.

Parameters:
- N1, 16, error sample width (signed, two's complement)
- N2, 16, coefficient width (signed)
- NTAP, 3, number of taps (>=2); error history depth = NTAP-1
- NH, 31, MSB of the accumulator slice driven on u_k
- NL, 0, LSB of the slice (fractional scaling); NW = NH-NL+1 is the output width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- stp  in  1  start-of-sample strobe, sampled on rising edge
- e_k  in  N1  current error sample, captured on the accepted-stp edge
- b  in  NTAP*N2  packed coefficients; b_i = b[i*N2 +: N2]; must be stable while busy=1
- u_k  out  NW  registered, saturated controller output
- sat  out  1  u_k was clipped on the last update
- busy  out  1  computation in progress
- eop  out  1  one-cycle end-of-process pulse, coincident with a new u_k

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; u_k, sat, busy, eop, accumulator, tap index and all history registers = 0.
- Reset mid-computation aborts the computation; no eop is issued.
- Accumulator width NA = N1+N2+clog2(NTAP)+2, signed; products and history are sign-extended before summation. No overflow is possible inside the accumulator.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - busy=0.
  - stp=1 -> MAC.
  - On that edge: e_cur <= e_k; idx <= 0; acc <= 0.
- MAC:
  - busy=1.
  - Each edge: acc <= acc + b_idx * tap_idx, where tap_0 = e_cur and tap_i = hist[i-1].
  - idx increments on each edge.
  - After the idx=NTAP-1 edge -> OUT.
- OUT:
  - busy=1.
  - r = acc >>> NL (arithmetic shift).
  - If r > 2^(NW-1)-1: u_k <= 2^(NW-1)-1, sat <= 1.
  - If r < -2^(NW-1): u_k <= -2^(NW-1), sat <= 1.
  - Otherwise: u_k <= r[NW-1:0], sat <= 0.
  - History shift: hist[0] <= e_cur; hist[j] <= hist[j-1].
  - eop <= 1 for exactly one cycle. Next state IDLE.
- Latency: stp accepted at edge t -> u_k/eop update at edge t+NTAP+1. Maximum throughput is one sample per NTAP+2 cycles.
- stp while busy=1 is ignored: no restart, no queuing, history untouched.
- stp on the same edge at which OUT returns to IDLE is ignored; stp is accepted only when the state is IDLE.
- u_k and sat hold between updates.
- Coefficient changes while busy=1 give undefined u_k for that sample only; the FSM is unaffected.

Optional Feature:
- Macro PD_FILTER_INCR_EN.
- Defined (incremental/velocity form):
  - On the stp-accept edge, acc <= sign_extend(u_k) << NL instead of 0, so u_k = u_(k-1) + sum b_i*e_(k-i).
  - Because u_k is the previous saturated output, integrator windup is bounded by saturation.
- Undefined: acc starts at 0 (positional form); no extra logic.

Test Plan:
- Reset and idle: rst=0 then 1, no stp for 20 cycles -> u_k=0, sat=0, busy=0, eop never asserted.
- Positional sequence, NTAP=3, NH=31, NL=0, b0=2, b1=-1, b2=1; stp with e_k=5, then 3, then -4:
  - u_k = 10, 1, -6 respectively.
  - Each eop arrives exactly 4 cycles after its stp edge.
  - busy=1 for 4 cycles per sample.
- Saturation, NH=15, NL=0, b0=32767, b1=b2=0:
  - e_k=32767 -> u_k=32767, sat=1.
  - e_k=-32768 -> u_k=-32768, sat=1.
  - e_k=10 -> u_k=327670 clipped to 32767, sat=1.
  - b0=1, e_k=10 -> u_k=10, sat=0.
- Busy protection: stp, then stp again 2 cycles later, then stp held high for 10 cycles -> exactly one eop per accepted start; history shifts once per eop.
- Reset mid-MAC: rst=0 asynchronously during idx=1 -> u_k=0, busy=0 immediately, no eop. The next sample computes from cleared history (e_k=5 with b above -> u_k=10).
- With PD_FILTER_INCR_EN defined: b0=1, b1=b2=0, three samples e_k=100 -> u_k = 100, 200, 300. With NH=15 and e_k=20000 twice -> u_k = 20000, then 32767 with sat=1.

Source files
------------

// File: rtl/pd_filter_ntap_if.sv
// rtl/pd_filter_ntap_if.sv - sample/coefficient/result bundle for the N-tap PD filter
interface pd_filter_ntap_if #(
    parameter int N1   = 16,
    parameter int N2   = 16,
    parameter int NTAP = 3,
    parameter int NW   = 32
);
    logic                   stp;
    logic signed [N1-1:0]   e_k;
    logic [NTAP*N2-1:0]     b;
    logic signed [NW-1:0]   u_k;
    logic                   sat;
    logic                   busy;
    logic                   eop;

    modport master (output stp, e_k, b, input u_k, sat, busy, eop);
    modport slave  (input stp, e_k, b, output u_k, sat, busy, eop);
endinterface

// File: rtl/pd_filter_ntap.sv
// rtl/pd_filter_ntap.sv - time-shared N-tap PD controller with saturating output window
// Optional incremental (velocity) form under macro PD_FILTER_INCR_EN.
module pd_filter_ntap #(
    parameter int N1   = 16,
    parameter int N2   = 16,
    parameter int NTAP = 3,
    parameter int NH   = 31,
    parameter int NL   = 0
) (
    input  logic             clk,
    input  logic             rst,
    pd_filter_ntap_if.slave  bus
);
    localparam int NW = NH - NL + 1;
    localparam int NA = N1 + N2 + $clog2(NTAP) + 2;
    localparam int IW = $clog2(NTAP);
    localparam int WX = ((NA > NW) ? NA : NW) + 1;
    localparam logic [IW-1:0] LAST = IW'(NTAP - 1);
    localparam logic signed [WX-1:0] UMAX = {{(WX-NW+1){1'b0}}, {(NW-1){1'b1}}};
    localparam logic signed [WX-1:0] UMIN = ~UMAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic signed [NA-1:0]   acc;
    logic signed [N1-1:0]   e_cur;
    logic signed [N1-1:0]   hist [NTAP-1];
    logic signed [NW-1:0]   u_k_r;
    logic                   sat_r, busy_r, eop_r;

    logic signed [N2-1:0]    b_sel;
    logic signed [N1-1:0]    tap_sel;
    logic signed [N1+N2-1:0] prod;
    logic signed [NA-1:0]    prod_x;
    logic signed [NA-1:0]    acc_sh;
    logic signed [WX-1:0]    r_x;

    // tap 0 is the sample captured at accept time, tap i>0 is hist[i-1]
    always_comb begin
        b_sel   = bus.b[N2-1:0];
        tap_sel = e_cur;
        for (int i = 1; i < NTAP; i++) begin
            if (idx == IW'(i)) begin
                b_sel   = bus.b[i*N2 +: N2];
                tap_sel = hist[i-1];
            end
        end
        prod   = b_sel * tap_sel;
        prod_x = {{(NA-N1-N2){prod[N1+N2-1]}}, prod};
        acc_sh = acc >>> NL;
        r_x    = {{(WX-NA){acc_sh[NA-1]}}, acc_sh};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            e_cur  <= '0;
            for (int j = 0; j < NTAP-1; j++) hist[j] <= '0;
            u_k_r  <= '0;
            sat_r  <= 1'b0;
            busy_r <= 1'b0;
            eop_r  <= 1'b0;
        end else begin
            eop_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.stp) begin
                        state  <= MAC;
                        busy_r <= 1'b1;
                        e_cur  <= bus.e_k;
                        idx    <= '0;
`ifdef PD_FILTER_INCR_EN
                        // velocity form: continue from the last saturated output
                        acc    <= {{(NA-NW){u_k_r[NW-1]}}, u_k_r} <<< NL;
`else
                        acc    <= '0;
`endif
                    end
                end
                MAC: begin
                    acc <= acc + prod_x;
                    idx <= idx + 1'b1;
                    if (idx == LAST) state <= OUT;
                end
                OUT: begin
                    if (r_x > UMAX) begin
                        u_k_r <= UMAX[NW-1:0];
                        sat_r <= 1'b1;
                    end else if (r_x < UMIN) begin
                        u_k_r <= UMIN[NW-1:0];
                        sat_r <= 1'b1;
                    end else begin
                        u_k_r <= r_x[NW-1:0];
                        sat_r <= 1'b0;
                    end
                    hist[0] <= e_cur;
                    for (int j = 1; j < NTAP-1; j++) hist[j] <= hist[j-1];
                    eop_r  <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.u_k  = u_k_r;
    assign bus.sat  = sat_r;
    assign bus.busy = busy_r;
    assign bus.eop  = eop_r;
endmodule

// File: tb/tb_pd_filter_ntap.sv
// tb/tb_pd_filter_ntap.sv - bench for pd_filter_ntap: 32-bit and 16-bit output instances vs arithmetic model
module tb_pd_filter_ntap;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               stp = 1'b0;
    logic signed [15:0] e_in = '0;
    logic [47:0]        b_vec = '0;
    int                 checks = 0;
    int                 errors = 0;

`ifdef PD_FILTER_INCR_EN
    localparam bit INCR = 1'b1;
`else
    localparam bit INCR = 1'b0;
`endif

    pd_filter_ntap_if #(.N1(16), .N2(16), .NTAP(3), .NW(32)) ifa ();
    pd_filter_ntap_if #(.N1(16), .N2(16), .NTAP(3), .NW(16)) ifs ();

    assign ifa.stp = stp;
    assign ifa.e_k = e_in;
    assign ifa.b   = b_vec;
    assign ifs.stp = stp;
    assign ifs.e_k = e_in;
    assign ifs.b   = b_vec;

    pd_filter_ntap #(.N1(16), .N2(16), .NTAP(3), .NH(31), .NL(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    pd_filter_ntap #(.N1(16), .N2(16), .NTAP(3), .NH(15), .NL(0)) dut_s (.clk(clk), .rst(rst), .bus(ifs));

    always #5 clk = ~clk;

    longint h [2];
    longint exp_a = 0, exp_s = 0;
    bit     sat_ea = 1'b0, sat_es = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint satv(input longint r, input int nw, output bit s);
        longint mx = (longint'(1) <<< (nw - 1)) - 1;
        longint mn = -mx - 1;
        s = 1'b1;
        if (r > mx) return mx;
        if (r < mn) return mn;
        s = 1'b0;
        return r;
    endfunction

    task automatic set_b(input longint b0, input longint b1, input longint b2);
        b_vec = {16'(b2), 16'(b1), 16'(b0)};
    endtask

    task automatic model_reset();
        h[0] = 0; h[1] = 0;
        exp_a = 0; exp_s = 0; sat_ea = 1'b0; sat_es = 1'b0;
    endtask

    // u_k = sum b_i*e_(k-i) (+ previous output in velocity form), then window clip
    task automatic model_apply(input longint e);
        longint taps [3];
        longint sum = 0;
        taps[0] = e; taps[1] = h[0]; taps[2] = h[1];
        for (int i = 0; i < 3; i++) begin
            logic signed [15:0] bi;
            bi = b_vec[i*16 +: 16];
            sum += longint'(bi) * taps[i];
        end
        exp_a = satv((INCR ? exp_a : 0) + sum, 32, sat_ea);
        exp_s = satv((INCR ? exp_s : 0) + sum, 16, sat_es);
        h[1] = h[0];
        h[0] = e;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_sample(input longint e, input bit glitch);
        @(negedge clk);
        stp  = 1'b1;
        e_in = 16'(e);
        @(posedge clk); #1;
        stp  = 1'b0;
        e_in = 16'($urandom);
        model_apply(e);
        check("busy_accept", ifa.busy, 1);
        check("eop_accept", ifa.eop, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("busy_mac", ifa.busy, 1);
            check("eop_mac", ifa.eop, 0);
            if (glitch && k == 1) begin
                stp  = 1'b1;
                e_in = 16'($urandom);
            end
        end
        @(posedge clk); #1;
        stp = 1'b0;
        check("eop_a", ifa.eop, 1);
        check("eop_s", ifs.eop, 1);
        check("busy_out", ifa.busy, 0);
        check("u_a", $signed(ifa.u_k), exp_a);
        check("sat_a", ifa.sat, sat_ea);
        check("u_s", $signed(ifs.u_k), exp_s);
        check("sat_s", ifs.sat, sat_es);
        @(posedge clk); #1;
        check("eop_clear", ifa.eop, 0);
        check("busy_idle", ifa.busy, 0);
    endtask

    initial begin
        int eops;
        longint e;
        model_reset();

        // reset and idle
        repeat (2) @(negedge clk);
        check("rst_u", $signed(ifa.u_k), 0);
        check("rst_busy", ifa.busy, 0);
        rst = 1'b1;
        eops = 0;
        repeat (20) begin
            @(posedge clk); #1;
            eops += int'(ifa.eop) + int'(ifs.eop);
        end
        check("idle_eops", eops, 0);
        check("idle_u", $signed(ifa.u_k), 0);
        check("idle_sat", ifa.sat, 0);
        check("idle_busy", ifa.busy, 0);

        // positional sequence
        set_b(2, -1, 1);
        run_sample(5, 1'b0);
`ifndef PD_FILTER_INCR_EN
        check("pos_u0", $signed(ifa.u_k), 10);
`endif
        run_sample(3, 1'b0);
`ifndef PD_FILTER_INCR_EN
        check("pos_u1", $signed(ifa.u_k), 1);
`endif
        run_sample(-4, 1'b1);
`ifndef PD_FILTER_INCR_EN
        check("pos_u2", $signed(ifa.u_k), -6);
`endif

        // saturation window on the 16-bit instance
        set_b(32767, 0, 0);
        run_sample(32767, 1'b0);
`ifndef PD_FILTER_INCR_EN
        check("sat_hi_u", $signed(ifs.u_k), 32767);
        check("sat_hi_f", ifs.sat, 1);
`endif
        run_sample(-32768, 1'b0);
`ifndef PD_FILTER_INCR_EN
        check("sat_lo_u", $signed(ifs.u_k), -32768);
        check("sat_lo_f", ifs.sat, 1);
`endif
        run_sample(10, 1'b0);
`ifndef PD_FILTER_INCR_EN
        check("sat_10_u", $signed(ifs.u_k), 32767);
`endif
        set_b(1, 0, 0);
        run_sample(10, 1'b0);
`ifndef PD_FILTER_INCR_EN
        check("nosat_u", $signed(ifs.u_k), 10);
        check("nosat_f", ifs.sat, 0);
`endif

        // stp held high for 10 edges: accepted at edges 0 and 5 only
        set_b(3, -2, 5);
        @(negedge clk);
        stp  = 1'b1;
        e_in = 16'sd77;
        eops = 0;
        repeat (10) begin
            @(posedge clk); #1;
            eops += int'(ifa.eop);
        end
        stp = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            eops += int'(ifa.eop);
        end
        model_apply(77);
        model_apply(77);
        check("hold_eops", eops, 2);
        check("hold_u_a", $signed(ifa.u_k), exp_a);
        check("hold_u_s", $signed(ifs.u_k), exp_s);
        run_sample(-123, 1'b0);

        // asynchronous reset while idx=1
        @(negedge clk);
        stp  = 1'b1;
        e_in = 16'sd7;
        @(posedge clk); #1;
        stp = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("amid_u", $signed(ifa.u_k), 0);
        check("amid_busy", ifa.busy, 0);
        check("amid_eop", ifa.eop, 0);
        @(negedge clk);
        rst = 1'b1;
        eops = 0;
        repeat (6) begin
            @(posedge clk); #1;
            eops += int'(ifa.eop);
        end
        check("amid_no_eop", eops, 0);
        set_b(2, -1, 1);
        run_sample(5, 1'b0);
        check("amid_next_u", $signed(ifa.u_k), 10);

        // randomized samples and coefficients
        for (int r = 0; r < 24; r++) begin
            if (r % 4 == 0)
                set_b(longint'($signed(16'($urandom))), longint'($signed(16'($urandom))),
                      longint'($signed(16'($urandom))));
            if (r % 2 == 0) e = longint'($urandom_range(0, 400)) - 200;
            else            e = longint'($signed(16'($urandom)));
            run_sample(e, 1'($urandom_range(0, 1)));
        end

`ifdef PD_FILTER_INCR_EN
        do_reset();
        set_b(1, 0, 0);
        run_sample(100, 1'b0);
        check("inc_u0", $signed(ifa.u_k), 100);
        run_sample(100, 1'b0);
        check("inc_u1", $signed(ifa.u_k), 200);
        run_sample(100, 1'b0);
        check("inc_u2", $signed(ifa.u_k), 300);
        do_reset();
        run_sample(20000, 1'b0);
        check("inc_s0", $signed(ifs.u_k), 20000);
        run_sample(20000, 1'b0);
        check("inc_s1", $signed(ifs.u_k), 32767);
        check("inc_s1_f", ifs.sat, 1);
`else
        do_reset();
        check("final_rst_u", $signed(ifa.u_k), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
